// File: rtl/xor_rr_scheduler.sv
// ---------------------------------------------------------------------------
// xor_rr_scheduler
//
// Shares one XOR datapath (input FIFO -> XOR -> output FIFO) between N_REQ
// requesters. A rotating-priority arbiter grants at most one requester per
// cycle. The granted operand pair goes straight to the datapath FIFO, and the
// requester ID is pushed into an in-order tag queue. Results come back in
// order. Each result pops the head tag and is steered to that requester one
// cycle later. An IDLE/RUN/DRAIN state machine controls issue. DRAIN gives a
// clean point to stop: it waits until every in-flight op has returned.
//
// Ports
//   clk, rst      : clock, synchronous active-high reset
//   en            : level, allows issue while in RUN
//   flush_req     : pulse, stop issuing and drain in-flight ops
//   flush_done    : one-cycle pulse on the cycle DRAIN is left
//   req_valid     : per-requester operand valid
//   req_data      : operand pairs, requester i on bits [2i+1:2i]
//   req_ready     : one-hot grant (combinational)
//   fifo_wr_en    : write strobe to datapath input FIFO
//   fifo_din      : granted operand pair, 0 when idle
//   fifo_full     : datapath input FIFO full
//   res_valid     : result valid from datapath
//   res_bit       : result bit
//   rsp_valid     : one-hot result strobe to the owning requester
//   rsp_data      : result bit
//   outstanding   : number of operations in flight
//   err_unexp     : sticky, a result arrived while nothing was in flight
// ---------------------------------------------------------------------------
module xor_rr_scheduler #(
   parameter int  N_REQ     = 4,
   parameter int  TAG_DEPTH = 8,
   localparam int IW        = (N_REQ > 1) ? $clog2(N_REQ) : 1,
   localparam int CW        = $clog2(TAG_DEPTH + 1),
   localparam int AW        = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 en,
   input  logic                 flush_req,
   output logic                 flush_done,
   input  logic [N_REQ-1:0]     req_valid,
   input  logic [2*N_REQ-1:0]   req_data,
   output logic [N_REQ-1:0]     req_ready,
   output logic                 fifo_wr_en,
   output logic [1:0]           fifo_din,
   input  logic                 fifo_full,
   input  logic                 res_valid,
   input  logic                 res_bit,
   output logic [N_REQ-1:0]     rsp_valid,
   output logic                 rsp_data,
   output logic [CW-1:0]        outstanding,
   output logic                 err_unexp
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_DRAIN = 2'd2
   } state_t;

   state_t              r_state;
   state_t              w_state_next;

   logic [IW-1:0]       r_ptr;
   logic [IW-1:0]       r_tag_mem [TAG_DEPTH];
   logic [AW-1:0]       r_wr_ptr;
   logic [AW-1:0]       r_rd_ptr;
   logic [CW-1:0]       r_count;
   logic [N_REQ-1:0]    r_rsp_valid;
   logic                r_rsp_data;
   logic                r_err;

   logic                w_found;
   logic [IW-1:0]       w_gnt_idx;
   logic                w_can_issue;
   logic                w_push;
   logic                w_pop;
   logic [IW-1:0]       w_head;
   logic [N_REQ-1:0]    w_head_onehot;

   // ------------------------------------------------------------------
   // Rotating-priority search: first valid index at or after r_ptr.
   // ------------------------------------------------------------------
   always_comb begin
      int w_scan;
      w_found   = 1'b0;
      w_gnt_idx = '0;
      w_scan    = 0;
      for (int k = 0; k < N_REQ; k++) begin
         w_scan = int'(r_ptr) + k;
         if (w_scan >= N_REQ) begin
            w_scan = w_scan - N_REQ;
         end
         if (!w_found && req_valid[w_scan]) begin
            w_found   = 1'b1;
            w_gnt_idx = IW'(w_scan);
         end
      end
   end

   // Full tag queue and full FIFO both block in the same cycle, so a push
   // can never happen at outstanding == TAG_DEPTH.
   assign w_can_issue = (r_state == S_RUN) && !fifo_full &&
                        (r_count < CW'(TAG_DEPTH));
   assign w_push      = w_can_issue && w_found;

   // A result with nothing in flight is flagged but never pops.
   assign w_pop       = res_valid && (r_count != '0);
   assign w_head      = r_tag_mem[r_rd_ptr];

   generate
      for (genvar gi = 0; gi < N_REQ; gi++) begin : g_onehot
         assign req_ready[gi]     = w_push && (w_gnt_idx == IW'(gi));
         assign w_head_onehot[gi] = (w_head == IW'(gi));
      end
   endgenerate

   assign fifo_wr_en = w_push;
   assign fifo_din   = w_push ? req_data[int'(w_gnt_idx)*2 +: 2] : 2'b00;

   // ------------------------------------------------------------------
   // Control state machine
   // ------------------------------------------------------------------
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (flush_req) begin
               w_state_next = S_DRAIN;
            end else if (en) begin
               w_state_next = S_RUN;
            end
         end
         S_RUN: begin
            if (flush_req) begin
               w_state_next = S_DRAIN;
            end else if (!en) begin
               w_state_next = S_IDLE;
            end
         end
         S_DRAIN: begin
            if (r_count == '0) begin
               w_state_next = S_IDLE;
            end
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   // The drain-complete pulse is the cycle in which DRAIN decides to exit.
   assign flush_done = (r_state == S_DRAIN) && (r_count == '0);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // ------------------------------------------------------------------
   // Arbitration pointer, tag queue pointers, count, response, error
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_ptr       <= '0;
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_count     <= '0;
         r_rsp_valid <= '0;
         r_rsp_data  <= 1'b0;
         r_err       <= 1'b0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_gnt_idx == IW'(N_REQ - 1)) begin
               r_ptr <= '0;
            end else begin
               r_ptr <= w_gnt_idx + 1'b1;
            end
         end

         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end

         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase

         r_rsp_valid <= w_pop ? w_head_onehot : '0;
         r_rsp_data  <= w_pop ? res_bit : 1'b0;

         if (res_valid && (r_count == '0)) begin
            r_err <= 1'b1;
         end
      end
   end

   // Tag storage holds no state that matters after reset, since the pointers
   // define which entries are live.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_tag_mem[r_wr_ptr] <= w_gnt_idx;
      end
   end

   assign rsp_valid   = r_rsp_valid;
   assign rsp_data    = r_rsp_data;
   assign outstanding = r_count;
   assign err_unexp   = r_err;

endmodule

// File: tb/tb_xor_rr_scheduler.sv
// ---------------------------------------------------------------------------
// tb_xor_rr_scheduler
//
// Directed bench for xor_rr_scheduler (N_REQ=4, TAG_DEPTH=8). Inputs change
// 1 time unit after the rising edge. All outputs are sampled on the falling
// edge of that same cycle.
// ---------------------------------------------------------------------------
module tb_xor_rr_scheduler;

   logic       clk;
   logic       rst;
   logic       en;
   logic       flush_req;
   logic       flush_done;
   logic [3:0] req_valid;
   logic [7:0] req_data;
   logic [3:0] req_ready;
   logic       fifo_wr_en;
   logic [1:0] fifo_din;
   logic       fifo_full;
   logic       res_valid;
   logic       res_bit;
   logic [3:0] rsp_valid;
   logic       rsp_data;
   logic [3:0] outstanding;
   logic       err_unexp;

   int n_checks = 0;
   int n_errors = 0;

   xor_rr_scheduler #(.N_REQ(4), .TAG_DEPTH(8)) dut (
      .clk         (clk),
      .rst         (rst),
      .en          (en),
      .flush_req   (flush_req),
      .flush_done  (flush_done),
      .req_valid   (req_valid),
      .req_data    (req_data),
      .req_ready   (req_ready),
      .fifo_wr_en  (fifo_wr_en),
      .fifo_din    (fifo_din),
      .fifo_full   (fifo_full),
      .res_valid   (res_valid),
      .res_bit     (res_bit),
      .rsp_valid   (rsp_valid),
      .rsp_data    (rsp_data),
      .outstanding (outstanding),
      .err_unexp   (err_unexp)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic       en;
      logic       flush;
      logic [3:0] valid;
      logic [7:0] data;
      logic       full;
      logic       rv;
      logic       rb;
      logic [3:0] e_ready;
      logic       e_wr;
      logic [1:0] e_din;
      logic [3:0] e_rsp;
      logic       e_rspd;
      logic [3:0] e_out;
      logic       e_fd;
      logic       e_err;
   } vec_t;

   localparam int NV = 15;
   vec_t vecs [NV];

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic set_in(input logic e, input logic f, input logic [3:0] v,
                         input logic [7:0] d, input logic fl,
                         input logic rv, input logic rb);
      en        = e;
      flush_req = f;
      req_valid = v;
      req_data  = d;
      fifo_full = fl;
      res_valid = rv;
      res_bit   = rb;
      @(negedge clk);
   endtask

   task automatic adv();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_all(input string name, input vec_t v);
      chk({name, ".ready"},  int'(req_ready),   int'(v.e_ready));
      chk({name, ".wr_en"},  int'(fifo_wr_en),  int'(v.e_wr));
      chk({name, ".din"},    int'(fifo_din),    int'(v.e_din));
      chk({name, ".rsp_v"},  int'(rsp_valid),   int'(v.e_rsp));
      chk({name, ".rsp_d"},  int'(rsp_data),    int'(v.e_rspd));
      chk({name, ".outst"},  int'(outstanding), int'(v.e_out));
      chk({name, ".fdone"},  int'(flush_done),  int'(v.e_fd));
      chk({name, ".err"},    int'(err_unexp),   int'(v.e_err));
   endtask

   task automatic do_reset();
      rst = 1'b1;
      set_in(1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 1'b0);
      adv();
      adv();
      rst = 1'b0;
   endtask

   initial begin
      vec_t z;
      string nm;
      z = '0;

      // Requester data E4: r3=11 r2=10 r1=01 r0=00.
      //            en    fl    valid  data   full  rv    rb    ready  wr    din    rsp    rspd  out    fd    err
      vecs[0]  = '{1'b1, 1'b0, 4'hF, 8'hE4, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 2'b00, 4'h0, 1'b0, 4'd0, 1'b0, 1'b0}; // IDLE, en registered
      vecs[1]  = '{1'b1, 1'b0, 4'hF, 8'hE4, 1'b0, 1'b0, 1'b0, 4'h1, 1'b1, 2'b00, 4'h0, 1'b0, 4'd0, 1'b0, 1'b0};
      vecs[2]  = '{1'b1, 1'b0, 4'hF, 8'hE4, 1'b0, 1'b0, 1'b0, 4'h2, 1'b1, 2'b01, 4'h0, 1'b0, 4'd1, 1'b0, 1'b0};
      vecs[3]  = '{1'b1, 1'b0, 4'hF, 8'hE4, 1'b0, 1'b0, 1'b0, 4'h4, 1'b1, 2'b10, 4'h0, 1'b0, 4'd2, 1'b0, 1'b0};
      vecs[4]  = '{1'b1, 1'b0, 4'hF, 8'hE4, 1'b0, 1'b0, 1'b0, 4'h8, 1'b1, 2'b11, 4'h0, 1'b0, 4'd3, 1'b0, 1'b0};
      vecs[5]  = '{1'b1, 1'b0, 4'hF, 8'hE4, 1'b0, 1'b0, 1'b0, 4'h1, 1'b1, 2'b00, 4'h0, 1'b0, 4'd4, 1'b0, 1'b0};
      vecs[6]  = '{1'b1, 1'b0, 4'h4, 8'hE4, 1'b0, 1'b0, 1'b0, 4'h4, 1'b1, 2'b10, 4'h0, 1'b0, 4'd5, 1'b0, 1'b0}; // ptr 1 -> 3
      vecs[7]  = '{1'b1, 1'b0, 4'h4, 8'hE4, 1'b0, 1'b0, 1'b0, 4'h4, 1'b1, 2'b10, 4'h0, 1'b0, 4'd6, 1'b0, 1'b0}; // ptr 3, wraps to 2
      vecs[8]  = '{1'b1, 1'b0, 4'hF, 8'hE4, 1'b0, 1'b0, 1'b0, 4'h8, 1'b1, 2'b11, 4'h0, 1'b0, 4'd7, 1'b0, 1'b0}; // ptr stayed 3
      vecs[9]  = '{1'b1, 1'b0, 4'hF, 8'hE4, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 2'b00, 4'h0, 1'b0, 4'd8, 1'b0, 1'b0}; // queue full
      vecs[10] = '{1'b1, 1'b0, 4'hF, 8'hE4, 1'b0, 1'b1, 1'b1, 4'h0, 1'b0, 2'b00, 4'h0, 1'b0, 4'd8, 1'b0, 1'b0}; // pop tag0 only
      vecs[11] = '{1'b1, 1'b0, 4'hF, 8'hE4, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 2'b00, 4'h1, 1'b1, 4'd7, 1'b0, 1'b0}; // fifo_full blocks
      vecs[12] = '{1'b1, 1'b0, 4'hF, 8'hE4, 1'b0, 1'b1, 1'b0, 4'h1, 1'b1, 2'b00, 4'h0, 1'b0, 4'd7, 1'b0, 1'b0}; // push+pop tag1
      vecs[13] = '{1'b1, 1'b0, 4'h0, 8'hE4, 1'b0, 1'b1, 1'b1, 4'h0, 1'b0, 2'b00, 4'h2, 1'b0, 4'd7, 1'b0, 1'b0}; // pop tag2
      vecs[14] = '{1'b1, 1'b0, 4'h0, 8'hE4, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 2'b00, 4'h4, 1'b1, 4'd6, 1'b0, 1'b0};

      en = 1'b0; flush_req = 1'b0; req_valid = '0; req_data = '0;
      fifo_full = 1'b0; res_valid = 1'b0; res_bit = 1'b0;

      // Reset state
      do_reset();
      set_in(1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 1'b0);
      chk_all("reset", z);
      $display("reset: ready=%b outst=%0d err=%b", req_ready, outstanding, err_unexp);
      adv();

      // Table: round-robin, single requester wrap, backpressure, fifo_full
      for (int i = 0; i < NV; i++) begin
         set_in(vecs[i].en, vecs[i].flush, vecs[i].valid, vecs[i].data,
                vecs[i].full, vecs[i].rv, vecs[i].rb);
         nm = $sformatf("vec%0d", i);
         chk_all(nm, vecs[i]);
         $display("vec %0d: valid=%b ready=%b wr=%b din=%b rsp=%b/%b outst=%0d",
                  i, req_valid, req_ready, fifo_wr_en, fifo_din, rsp_valid, rsp_data, outstanding);
         adv();
      end

      // Routing: req1 sends 10, req3 sends 11, results 1 then 0
      do_reset();
      set_in(1'b1, 1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 1'b0); adv();
      set_in(1'b1, 1'b0, 4'h2, 8'h08, 1'b0, 1'b0, 1'b0);
      chk("route.ready1", int'(req_ready), 4'h2);
      chk("route.din1",   int'(fifo_din), 2'b10);
      adv();
      set_in(1'b1, 1'b0, 4'h8, 8'hC0, 1'b0, 1'b0, 1'b0);
      chk("route.ready3", int'(req_ready), 4'h8);
      chk("route.din3",   int'(fifo_din), 2'b11);
      adv();
      set_in(1'b1, 1'b0, 4'h0, 8'h00, 1'b0, 1'b1, 1'b1);
      chk("route.outst2", int'(outstanding), 2);
      chk("route.rsp_pre", int'(rsp_valid), 0);
      adv();
      set_in(1'b1, 1'b0, 4'h0, 8'h00, 1'b0, 1'b1, 1'b0);
      chk("route.rsp_v1", int'(rsp_valid), 4'h2);
      chk("route.rsp_d1", int'(rsp_data), 1);
      adv();
      set_in(1'b1, 1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 1'b0);
      chk("route.rsp_v3", int'(rsp_valid), 4'h8);
      chk("route.rsp_d3", int'(rsp_data), 0);
      chk("route.outst0", int'(outstanding), 0);
      adv();
      set_in(1'b1, 1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 1'b0);
      chk("route.rsp_off", int'(rsp_valid), 0);
      $display("routing sequence done: outst=%0d", outstanding);
      adv();

      // Simultaneous push/pop at outstanding=3 (ptr=0, grants 0,1,2)
      for (int i = 0; i < 3; i++) begin
         set_in(1'b1, 1'b0, 4'hF, 8'hE4, 1'b0, 1'b0, 1'b0); adv();
      end
      set_in(1'b1, 1'b0, 4'hF, 8'hE4, 1'b0, 1'b1, 1'b1);
      chk("pp.ready", int'(req_ready), 4'h8);
      chk("pp.outst_before", int'(outstanding), 3);
      adv();
      // Flush with three in flight (tags 1,2,3 remain)
      set_in(1'b0, 1'b1, 4'h0, 8'hE4, 1'b0, 1'b0, 1'b0);
      chk("pp.outst_after", int'(outstanding), 3);
      chk("pp.rsp_oldest", int'(rsp_valid), 4'h1);
      chk("pp.rsp_d", int'(rsp_data), 1);
      adv();
      set_in(1'b0, 1'b0, 4'hF, 8'hE4, 1'b0, 1'b0, 1'b0);
      chk("flush.no_grant", int'(req_ready), 0);
      chk("flush.no_wr", int'(fifo_wr_en), 0);
      adv();
      set_in(1'b0, 1'b0, 4'hF, 8'hE4, 1'b0, 1'b1, 1'b0); adv();
      set_in(1'b0, 1'b0, 4'hF, 8'hE4, 1'b0, 1'b1, 1'b1);
      chk("flush.rsp1", int'(rsp_valid), 4'h2);
      adv();
      set_in(1'b0, 1'b0, 4'hF, 8'hE4, 1'b0, 1'b1, 1'b0);
      chk("flush.rsp2", int'(rsp_valid), 4'h4);
      chk("flush.fd_early", int'(flush_done), 0);
      chk("flush.no_grant2", int'(req_ready), 0);
      adv();
      set_in(1'b0, 1'b0, 4'hF, 8'hE4, 1'b0, 1'b0, 1'b0);
      chk("flush.rsp3", int'(rsp_valid), 4'h8);
      chk("flush.done", int'(flush_done), 1);
      chk("flush.outst0", int'(outstanding), 0);
      adv();
      set_in(1'b0, 1'b0, 4'hF, 8'hE4, 1'b0, 1'b0, 1'b0);
      chk("flush.done_once", int'(flush_done), 0);
      chk("flush.idle_ready", int'(req_ready), 0);
      $display("flush sequence done: outst=%0d", outstanding);
      adv();

      // Unexpected result with an empty queue
      set_in(1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 1'b1, 1'b1);
      chk("err.before", int'(err_unexp), 0);
      adv();
      set_in(1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 1'b0);
      chk("err.set", int'(err_unexp), 1);
      chk("err.no_rsp", int'(rsp_valid), 0);
      chk("err.outst", int'(outstanding), 0);
      adv();

      // Reset with two in flight (ptr 0 -> grants 0,1, ptr becomes 2)
      set_in(1'b1, 1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 1'b0); adv();
      set_in(1'b1, 1'b0, 4'hF, 8'hE4, 1'b0, 1'b0, 1'b0); adv();
      set_in(1'b1, 1'b0, 4'hF, 8'hE4, 1'b0, 1'b0, 1'b0);
      chk("rst.pre_outst", int'(outstanding), 1);
      adv();
      do_reset();
      set_in(1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 1'b0);
      chk_all("rst.after", z);
      adv();
      set_in(1'b1, 1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 1'b0); adv();
      set_in(1'b1, 1'b0, 4'hF, 8'hE4, 1'b0, 1'b0, 1'b0);
      chk("rst.ptr0", int'(req_ready), 4'h1);
      $display("reset sequence done: ready=%b err=%b", req_ready, err_unexp);
      adv();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/xor_rr_scheduler.md
# xor_rr_scheduler

Round-robin scheduler that shares one 2-bit-operand XOR datapath (input FIFO → XOR stage → output FIFO) between N_REQ requesters. Each cycle it grants at most one requester, writes that operand pair into the datapath input FIFO, and records the requester ID in an in-order tag queue. When the result bit returns from the datapath, it is routed back to the originating requester. An enable/flush state machine gates issue and provides a clean drain point for reconfiguration.

## Interface
- N_REQ, 4, number of requesters (≥2); ID width IW = $clog2(N_REQ)
- TAG_DEPTH, 8, maximum in-flight operations; tag queue depth (power of 2)
- clk  in  1  rising-edge clock
- rst  in  1  reset; synchronous and active-high
- en  in  1  level; allows issue while in RUN
- flush_req  in  1  pulse; stop issue, drain in-flight ops
- flush_done  out  1  one-cycle pulse when drain completes
- req_valid  in  N_REQ  per-requester operand valid
- req_data  in  2*N_REQ  operand pair; requester i uses bits [2i+1:2i] ({a,b})
- req_ready  out  N_REQ  one-hot grant; at most one bit set
- fifo_wr_en  out  1  write strobe to datapath input FIFO
- fifo_din  out  2  operand pair to datapath
- fifo_full  in  1  datapath input FIFO full
- res_valid  in  1  result bit valid from datapath output
- res_bit  in  1  XOR result
- rsp_valid  out  N_REQ  one-hot result strobe to requester
- rsp_data  out  1  result bit
- outstanding  out  $clog2(TAG_DEPTH+1)  in-flight count
- err_unexp  out  1  sticky: res_valid seen with empty tag queue

## Operation
- FSM states: IDLE, RUN, DRAIN. Reset → IDLE.
- IDLE: no grants. en=1 → RUN. flush_req in IDLE → DRAIN.
- RUN: grants allowed. en=0 → IDLE (in-flight results still routed). flush_req → DRAIN (flush_req takes priority over en).
- DRAIN: no grants. When outstanding==0 → pulse flush_done and go to IDLE. The pulse occurs on the cycle the FSM leaves DRAIN.
- Grant condition: state==RUN, fifo_full==0, outstanding<TAG_DEPTH, and at least one req_valid.
- Arbitration: rotating priority starting at pointer ptr. The first valid index at or after ptr (mod N_REQ) wins.
  - req_ready is combinational from req_valid, ptr, state, fifo_full and count. Ready may depend on valid.
- Transfer: req_valid[i] & req_ready[i]. Same cycle: fifo_wr_en=1 and fifo_din=req_data of i (combinational). Tag i is pushed at the clock edge. ptr ← (i+1) mod N_REQ.
- No transfer: ptr holds, fifo_wr_en=0, fifo_din=0.
- Return: res_valid with non-empty queue pops the head tag h. Next cycle: rsp_valid = one-hot(h), rsp_data = res_bit.
  - Results are strictly in order; the datapath preserves order.
- Return with empty queue: no pop, no rsp. err_unexp ← 1 until rst.
- Simultaneous push and pop: both occur; outstanding is unchanged.
  - Allowed even at outstanding==TAG_DEPTH? No: the grant is already blocked at full, so only a pop occurs.
- Count arithmetic: outstanding += push − pop. It never exceeds TAG_DEPTH and never underflows.
- rst mid-operation: the queue is emptied, ptr=0, state=IDLE, err cleared, and in-flight results are discarded.
  - The datapath must be reset by the same rst.

## Timing
- Reset values: req_ready=0, fifo_wr_en=0, fifo_din=0, rsp_valid=0, rsp_data=0, outstanding=0, flush_done=0, err_unexp=0; ptr=0.
- Issue latency: 0 cycles (valid → wr_en in the same cycle when granted).
- Throughput: one grant per cycle.
- Response latency: 1 cycle from res_valid to rsp_valid.
- en=1 sampled at edge k → first grant possible in cycle k+1 (RUN registered).
- flush_req at edge k → no grant from cycle k+1.
- fifo_full and count limit act in the same cycle: no wr_en while fifo_full=1.

## Test plan
- Round-robin: en=1, all four req_valid held, fifo_full=0.
  - Grants 0,1,2,3,0,… one per cycle.
  - Only req 2 valid, ptr=3 → grant 2, ptr becomes 3.
- Routing: req1 sends 2'b10, then req3 sends 2'b11. Return res_bit 1 then 0.
  - rsp_valid=4'b0010 with rsp_data=1, then 4'b1000 with rsp_data=0, each one cycle after its res_valid.
- Backpressure: TAG_DEPTH=8, no returns.
  - 8 grants, then req_ready=0 while outstanding=8.
  - fifo_full=1 at any count → req_ready=0, fifo_wr_en=0.
- Simultaneous push/pop: outstanding=3, grant and res_valid in the same cycle → outstanding stays 3.
  - Response goes to the oldest tag.
- Flush: 3 in flight, pulse flush_req.
  - No further grants.
  - After the 3rd result returns, flush_done pulses once, state goes to IDLE, outstanding=0.
- Error/reset: res_valid with empty queue → err_unexp=1, no rsp_valid. Then rst with 2 in flight → all outputs 0, err_unexp=0.
